dr_memreq_arb: RTL and testbench



---
 rtl/dr_memreq_arb.sv | 143 ++++++++++++++
 tb/tb_dr_memreq_arb.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dr_memreq_arb.sv
// Memory request arbiter for a directory bank.
// It shares one memory request channel between two sources:
//   - demand misses, which can be backpressured, and
//   - L2 prefetches, which are held in a small drop-oldest queue and never backpressured.
// Demand wins by default. A starvation counter forces a prefetch grant after
// PF_STARVE consecutive demand grants while prefetches are waiting.
module dr_memreq_arb #(
    parameter int                PF_DEPTH  = 4,
    parameter int                PF_STARVE = 8,
    parameter int                DRID_W    = 8,
    parameter int                CMD_W     = 4,
    parameter int                PADDR_W   = 32,
    parameter logic [CMD_W-1:0]  PF_CMD    = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          dem_valid,
    output logic                          dem_retry,
    input  logic [DRID_W-1:0]             dem_drid,
    input  logic [CMD_W-1:0]              dem_cmd,
    input  logic [PADDR_W-1:0]            dem_paddr,
    input  logic                          pf_valid,
    output logic                          pf_retry,
    input  logic [PADDR_W-1:0]            pf_paddr,
    output logic                          drtomem_req_valid,
    input  logic                          drtomem_req_retry,
    output logic [DRID_W-1:0]             drtomem_req_drid,
    output logic [CMD_W-1:0]              drtomem_req_cmd,
    output logic [PADDR_W-1:0]            drtomem_req_paddr,
    output logic [$clog2(PF_DEPTH+1)-1:0] pf_occupancy,
    output logic [15:0]                   pf_drop_count
);

    localparam int                 PTR_W      = $clog2(PF_DEPTH);
    localparam int                 OCC_W      = $clog2(PF_DEPTH + 1);
    localparam logic [OCC_W-1:0]   OCC_FULL   = OCC_W'(PF_DEPTH);
    localparam logic [7:0]         STARVE_MAX = 8'(PF_STARVE);

    logic [PADDR_W-1:0] pf_mem [PF_DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [7:0]         starve_cnt;
    logic               out_valid;

    logic load_en;
    logic pf_nonempty;
    logic pf_full;
    logic push;
    logic sel_pf;
    logic sel_dem;

    assign load_en     = !out_valid || !drtomem_req_retry;
    assign pf_nonempty = (pf_occupancy != '0);
    assign pf_full     = (pf_occupancy == OCC_FULL);
    assign push        = pf_valid && !reset;
    assign pf_retry    = 1'b0;

    // A pending entry is never presented during reset, so no transfer can happen in a reset cycle.
    assign drtomem_req_valid = out_valid && !reset;

    // Arbitration: choose a source for the output stage whenever it can load.
    always_comb begin
        // NOTE: each output gets a default first, so no path leaves it unassigned and no latch is inferred.
        sel_pf  = 1'b0;
        sel_dem = 1'b0;
        if (load_en) begin
            if (pf_nonempty && (!dem_valid || starve_cnt == STARVE_MAX)) begin
                sel_pf = 1'b1;
            end else if (dem_valid) begin
                sel_dem = 1'b1;
            end
        end
        dem_retry = reset || !load_en || sel_pf;
    end

    // Output stage: one registered request, held stable until memory accepts it.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
        if (reset) begin
            out_valid         <= 1'b0;
            drtomem_req_drid  <= '0;
            drtomem_req_cmd   <= '0;
            drtomem_req_paddr <= '0;
        end else if (load_en) begin
            out_valid <= sel_pf || sel_dem;
            if (sel_pf) begin
                drtomem_req_drid  <= '0;
                drtomem_req_cmd   <= PF_CMD;
                drtomem_req_paddr <= pf_mem[head];
            end else if (sel_dem) begin
                drtomem_req_drid  <= dem_drid;
                drtomem_req_cmd   <= dem_cmd;
                drtomem_req_paddr <= dem_paddr;
            end
        end
    end

    // Prefetch storage. When the queue is full, tail equals head, so a push overwrites the oldest entry.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset. Pointers and occupancy decide which entries are valid.
        if (push) begin
            pf_mem[tail] <= pf_paddr;
        end
    end

    // Queue control: pointers, exact occupancy and saturating drop counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            head          <= '0;
            tail          <= '0;
            pf_occupancy  <= '0;
            pf_drop_count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (sel_pf || (push && pf_full)) begin
                head <= head + PTR_W'(1);
            end
            if (push && !sel_pf) begin
                if (!pf_full) begin
                    pf_occupancy <= pf_occupancy + OCC_W'(1);
                end else if (pf_drop_count != 16'hFFFF) begin
                    pf_drop_count <= pf_drop_count + 16'd1;
                end
            end else if (!push && sel_pf) begin
                pf_occupancy <= pf_occupancy - OCC_W'(1);
            end
        end
    end

    // Starvation counter: counts demand wins while prefetches wait, saturating at the limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (sel_pf || !pf_nonempty) begin
            starve_cnt <= '0;
        end else if (sel_dem && starve_cnt != STARVE_MAX) begin
            starve_cnt <= starve_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_dr_memreq_arb.sv
// Directed testbench for dr_memreq_arb.
// The main checks come from a table of per-cycle vectors. Hand-written sequences
// cover reset, starvation and reset in the middle of operation.
module tb_dr_memreq_arb;

    localparam logic [3:0] PFC = 4'hE;

    logic        clk;
    logic        reset;
    logic        dem_valid;
    logic        dem_retry;
    logic [7:0]  dem_drid;
    logic [3:0]  dem_cmd;
    logic [31:0] dem_paddr;
    logic        pf_valid;
    logic        pf_retry;
    logic [31:0] pf_paddr;
    logic        drtomem_req_valid;
    logic        drtomem_req_retry;
    logic [7:0]  drtomem_req_drid;
    logic [3:0]  drtomem_req_cmd;
    logic [31:0] drtomem_req_paddr;
    logic [2:0]  pf_occupancy;
    logic [15:0] pf_drop_count;

    int n_pass  = 0;
    int n_total = 0;

    dr_memreq_arb #(
        .PF_DEPTH (4),
        .PF_STARVE(8),
        .DRID_W   (8),
        .CMD_W    (4),
        .PADDR_W  (32),
        .PF_CMD   (PFC)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .dem_valid        (dem_valid),
        .dem_retry        (dem_retry),
        .dem_drid         (dem_drid),
        .dem_cmd          (dem_cmd),
        .dem_paddr        (dem_paddr),
        .pf_valid         (pf_valid),
        .pf_retry         (pf_retry),
        .pf_paddr         (pf_paddr),
        .drtomem_req_valid(drtomem_req_valid),
        .drtomem_req_retry(drtomem_req_retry),
        .drtomem_req_drid (drtomem_req_drid),
        .drtomem_req_cmd  (drtomem_req_cmd),
        .drtomem_req_paddr(drtomem_req_paddr),
        .pf_occupancy     (pf_occupancy),
        .pf_drop_count    (pf_drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        dv;
        logic [7:0]  drid;
        logic [3:0]  cmd;
        logic [31:0] pa;
        logic        pv;
        logic [31:0] pp;
        logic        rt;
        logic        e_dretry;
        logic        e_valid;
        logic [7:0]  e_drid;
        logic [3:0]  e_cmd;
        logic [31:0] e_pa;
        logic [2:0]  e_occ;
        logic [15:0] e_drop;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(logic dv, logic [7:0] drid, logic [3:0] cmd, logic [31:0] pa,
                                logic pv, logic [31:0] pp, logic rt,
                                logic edr, logic ev, logic [7:0] ed, logic [3:0] ec,
                                logic [31:0] ep, logic [2:0] eo, logic [15:0] edp);
        vec_t v;
        v.dv = dv; v.drid = drid; v.cmd = cmd; v.pa = pa;
        v.pv = pv; v.pp = pp; v.rt = rt;
        v.e_dretry = edr; v.e_valid = ev; v.e_drid = ed; v.e_cmd = ec;
        v.e_pa = ep; v.e_occ = eo; v.e_drop = edp;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Drive one vector at the falling edge, check dem_retry before the rising edge,
    // then check the registered outputs just after it.
    task automatic run_vec(input vec_t t, input string tag);
        @(negedge clk);
        dem_valid         = t.dv;
        dem_drid          = t.drid;
        dem_cmd           = t.cmd;
        dem_paddr         = t.pa;
        pf_valid          = t.pv;
        pf_paddr          = t.pp;
        drtomem_req_retry = t.rt;
        #1;
        check({tag, ".dem_retry"}, 32'(dem_retry), 32'(t.e_dretry));
        @(posedge clk);
        #1;
        check({tag, ".valid"}, 32'(drtomem_req_valid), 32'(t.e_valid));
        check({tag, ".occ"}, 32'(pf_occupancy), 32'(t.e_occ));
        check({tag, ".drop"}, 32'(pf_drop_count), 32'(t.e_drop));
        if (t.e_valid) begin
            check({tag, ".drid"}, 32'(drtomem_req_drid), 32'(t.e_drid));
            check({tag, ".cmd"}, 32'(drtomem_req_cmd), 32'(t.e_cmd));
            check({tag, ".paddr"}, drtomem_req_paddr, t.e_pa);
        end
    endtask

    initial begin
        int idx;

        reset = 1'b1;
        dem_valid = 1'b0; dem_drid = '0; dem_cmd = '0; dem_paddr = '0;
        pf_valid = 1'b0; pf_paddr = '0; drtomem_req_retry = 1'b0;

        // Reset, then idle.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.dem_retry", 32'(dem_retry), 32'd1);
        check("rst.valid", 32'(drtomem_req_valid), 32'd0);
        reset = 1'b0;
        #1;
        check("idle.dem_retry", 32'(dem_retry), 32'd0);
        check("idle.valid", 32'(drtomem_req_valid), 32'd0);
        check("idle.occ", 32'(pf_occupancy), 32'd0);
        check("idle.drop", 32'(pf_drop_count), 32'd0);
        check("idle.pf_retry", 32'(pf_retry), 32'd0);

        // Columns: dv, drid, cmd, paddr, pv, pf_paddr, mem_retry |
        //          exp dem_retry, valid, drid, cmd, paddr, occupancy, drops.
        // Single demand, then backpressure while a second demand waits.
        tv.push_back(mk(0, 0, 0, 0,      0, 0, 0,  0, 0, 0, 0, 0,      0, 0));
        tv.push_back(mk(1, 5, 3, 'h1000, 0, 0, 0,  0, 1, 5, 3, 'h1000, 0, 0));
        tv.push_back(mk(0, 0, 0, 0,      0, 0, 0,  0, 0, 0, 0, 0,      0, 0));
        tv.push_back(mk(1, 6, 1, 'h2000, 0, 0, 0,  0, 1, 6, 1, 'h2000, 0, 0));
        tv.push_back(mk(1, 7, 2, 'h3000, 0, 0, 1,  1, 1, 6, 1, 'h2000, 0, 0));
        tv.push_back(mk(1, 7, 2, 'h3000, 0, 0, 1,  1, 1, 6, 1, 'h2000, 0, 0));
        tv.push_back(mk(1, 7, 2, 'h3000, 0, 0, 1,  1, 1, 6, 1, 'h2000, 0, 0));
        tv.push_back(mk(1, 7, 2, 'h3000, 0, 0, 0,  0, 1, 7, 2, 'h3000, 0, 0));
        tv.push_back(mk(0, 0, 0, 0,      0, 0, 0,  0, 0, 0, 0, 0,      0, 0));
        // Drop-oldest: six pushes into four entries while the output is blocked.
        tv.push_back(mk(1, 9, 4, 'h4000, 1, 'h100, 0,  0, 1, 9, 4, 'h4000, 1, 0));
        tv.push_back(mk(0, 0, 0, 0,      1, 'h200, 1,  1, 1, 9, 4, 'h4000, 2, 0));
        tv.push_back(mk(0, 0, 0, 0,      1, 'h300, 1,  1, 1, 9, 4, 'h4000, 3, 0));
        tv.push_back(mk(0, 0, 0, 0,      1, 'h400, 1,  1, 1, 9, 4, 'h4000, 4, 0));
        tv.push_back(mk(0, 0, 0, 0,      1, 'h500, 1,  1, 1, 9, 4, 'h4000, 4, 1));
        tv.push_back(mk(0, 0, 0, 0,      1, 'h600, 1,  1, 1, 9, 4, 'h4000, 4, 2));
        tv.push_back(mk(0, 0, 0, 0,      0, 0, 0,  1, 1, 0, PFC, 'h300, 3, 2));
        tv.push_back(mk(0, 0, 0, 0,      0, 0, 0,  1, 1, 0, PFC, 'h400, 2, 2));
        tv.push_back(mk(0, 0, 0, 0,      0, 0, 0,  1, 1, 0, PFC, 'h500, 1, 2));
        tv.push_back(mk(0, 0, 0, 0,      0, 0, 0,  1, 1, 0, PFC, 'h600, 0, 2));
        tv.push_back(mk(0, 0, 0, 0,      0, 0, 0,  0, 0, 0, 0, 0,      0, 2));
        // A push and a pop while full: no drop, occupancy unchanged.
        tv.push_back(mk(1, 1, 0, 'h5000, 1, 'h700, 0,  0, 1, 1, 0, 'h5000, 1, 2));
        tv.push_back(mk(0, 0, 0, 0,      1, 'h800, 1,  1, 1, 1, 0, 'h5000, 2, 2));
        tv.push_back(mk(0, 0, 0, 0,      1, 'h900, 1,  1, 1, 1, 0, 'h5000, 3, 2));
        tv.push_back(mk(0, 0, 0, 0,      1, 'hA00, 1,  1, 1, 1, 0, 'h5000, 4, 2));
        tv.push_back(mk(0, 0, 0, 0,      1, 'hB00, 0,  1, 1, 0, PFC, 'h700, 4, 2));
        tv.push_back(mk(0, 0, 0, 0,      0, 0, 0,  1, 1, 0, PFC, 'h800, 3, 2));
        tv.push_back(mk(0, 0, 0, 0,      0, 0, 0,  1, 1, 0, PFC, 'h900, 2, 2));
        tv.push_back(mk(0, 0, 0, 0,      0, 0, 0,  1, 1, 0, PFC, 'hA00, 1, 2));
        tv.push_back(mk(0, 0, 0, 0,      0, 0, 0,  1, 1, 0, PFC, 'hB00, 0, 2));
        tv.push_back(mk(0, 0, 0, 0,      0, 0, 0,  0, 0, 0, 0, 0,      0, 2));
        // Minimum prefetch latency: a push is not selectable until the next cycle.
        tv.push_back(mk(0, 0, 0, 0,      1, 'hC00, 0,  0, 0, 0, 0, 0,      1, 2));
        tv.push_back(mk(0, 0, 0, 0,      0, 0, 0,  1, 1, 0, PFC, 'hC00, 0, 2));
        tv.push_back(mk(0, 0, 0, 0,      0, 0, 0,  0, 0, 0, 0, 0,      0, 2));

        foreach (tv[i]) begin
            run_vec(tv[i], $sformatf("v%0d", i));
        end

        // Starvation: one queued prefetch against a continuous demand stream.
        run_vec(mk(0, 0, 0, 0, 1, 'hD00, 0,  0, 0, 0, 0, 0, 1, 2), "starve_push");
        idx = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            dem_valid         = 1'b1;
            dem_drid          = 8'(8'h20 + idx);
            dem_cmd           = 4'h5;
            dem_paddr         = 32'(32'h8000 + idx);
            pf_valid          = 1'b0;
            drtomem_req_retry = 1'b0;
            #1;
            check($sformatf("starve%0d.dem_retry", i), 32'(dem_retry), 32'(i == 8));
            @(posedge clk);
            #1;
            check($sformatf("starve%0d.valid", i), 32'(drtomem_req_valid), 32'd1);
            if (i == 8) begin
                check("starve8.drid", 32'(drtomem_req_drid), 32'd0);
                check("starve8.cmd", 32'(drtomem_req_cmd), 32'(PFC));
                check("starve8.paddr", drtomem_req_paddr, 32'hD00);
            end else begin
                check($sformatf("starve%0d.drid", i), 32'(drtomem_req_drid), 32'(8'h20 + idx));
                check($sformatf("starve%0d.paddr", i), drtomem_req_paddr, 32'(32'h8000 + idx));
                idx++;
            end
        end
        check("starve.cnt_cleared", 32'(dut.starve_cnt), 32'd0);
        run_vec(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 2), "starve_drain");

        // Reset in the middle of operation: three queued prefetches and one pending request.
        run_vec(mk(1, 'h11, 2, 'h6000, 0, 0,     0,  0, 1, 'h11, 2, 'h6000, 0, 2), "mid_a");
        run_vec(mk(0, 0, 0, 0,         1, 'hE00, 1,  1, 1, 'h11, 2, 'h6000, 1, 2), "mid_b");
        run_vec(mk(0, 0, 0, 0,         1, 'hF00, 1,  1, 1, 'h11, 2, 'h6000, 2, 2), "mid_c");
        run_vec(mk(0, 0, 0, 0,         1, 'h1100, 1, 1, 1, 'h11, 2, 'h6000, 3, 2), "mid_d");
        @(negedge clk);
        reset    = 1'b1;
        pf_valid = 1'b0;
        #1;
        check("midrst.dem_retry", 32'(dem_retry), 32'd1);
        check("midrst.valid_in_reset", 32'(drtomem_req_valid), 32'd0);
        @(posedge clk);
        #1;
        check("midrst.valid", 32'(drtomem_req_valid), 32'd0);
        check("midrst.occ", 32'(pf_occupancy), 32'd0);
        check("midrst.drop", 32'(pf_drop_count), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            run_vec(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0), $sformatf("post_rst%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
